// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy flags, programmable thresholds and overflow/underflow pulses.
// Define SYNC_FIFO_WATERMARK_EN to add the peak-occupancy tracker (wm_clr / max_cnt).
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_vld,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fifo_cnt,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    input  logic                  wm_clr,
    output logic [ADDR_WIDTH:0]   max_cnt
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, r_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_vld, r_empty, r_full, r_aempty, r_afull, r_ovf, r_udf;

    logic                  w_rd_acc, w_wr_acc;
    logic [ADDR_WIDTH:0]   w_cnt_next;
    logic [ADDR_WIDTH:0]   w_wr_inc, w_rd_inc;

    // A full FIFO still takes a write when the same edge frees a slot; empty never bypasses.
    assign w_rd_acc   = rd_en & ~r_empty;
    assign w_wr_acc   = wr_en & (~r_full | w_rd_acc);
    assign w_wr_inc   = {{ADDR_WIDTH{1'b0}}, w_wr_acc};
    assign w_rd_inc   = {{ADDR_WIDTH{1'b0}}, w_rd_acc};
    assign w_cnt_next = r_cnt + w_wr_inc - w_rd_inc;

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_aempty  <= 1'b1;
            r_afull   <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_wr_inc;
            r_rd_ptr <= r_rd_ptr + w_rd_inc;
            r_cnt    <= w_cnt_next;
            r_rd_vld <= w_rd_acc;
            // Read of the slot being overwritten at full returns the old word.
            if (w_rd_acc)
                r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_empty  <= (w_cnt_next == '0);
            r_full   <= (w_cnt_next == DEPTH_C);
            r_aempty <= (w_cnt_next <= AE_C);
            r_afull  <= (w_cnt_next >= AF_C);
            r_ovf    <= wr_en & ~w_wr_acc;
            r_udf    <= rd_en & ~w_rd_acc;
        end
    end

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [ADDR_WIDTH:0] r_max_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_max_cnt <= '0;
        else if (wm_clr)
            r_max_cnt <= w_cnt_next;
        else if (w_cnt_next > r_max_cnt)
            r_max_cnt <= w_cnt_next;
    end

    assign max_cnt = r_max_cnt;
`endif

    assign rd_data      = r_rd_data;
    assign rd_vld       = r_rd_vld;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_aempty;
    assign almost_full  = r_afull;
    assign fifo_cnt     = r_cnt;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
